// File: rtl/serial_addsub_word.sv
// ---------------------------------------------------------------------------
// serial_addsub_word
//
// Word-framed bit-serial adder/subtractor. Operand bits arrive LSB first, one
// a/b pair per accepted cycle. A single carry flop is threaded through the
// word, one registered sum bit is emitted per accepted pair, and after WIDTH
// bits the parallel result, final carry and signed overflow are presented.
// Subtraction is performed as a + ~b + 1: b is inverted on the fly and the
// carry flop is preloaded with 1 when the word starts.
//
// Parameters:
//   WIDTH      bits per word, 2..32
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low (0 = reset)
//   start      begin a new word; only honoured while idle
//   sub        mode sampled together with start: 0 = a+b, 1 = a-b
//   in_valid   a/b bit pair is valid this cycle
//   a, b       serial operand bits, LSB first
//   sum_bit    registered serial result bit
//   out_valid  sum_bit carries a new bit this cycle
//   busy       high while a word is in flight (RUN and DONE)
//   done       one-cycle pulse marking word completion
//   sum_word   parallel result, held until the next accepted start
//   carry_out  final carry (for subtract: 1 = no borrow, a >= b unsigned)
//   overflow   two's-complement signed overflow of the word
// ---------------------------------------------------------------------------
module serial_addsub_word #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   output logic             sum_bit,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_word,
   output logic             carry_out,
   output logic             overflow
);

   // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic             mode;
   logic             carry;
   logic [CNT_W-1:0] bit_cnt;

   logic             b_eff;
   logic             s_bit;
   logic             c_next;
   logic             accept;
   logic             last_accept;

   // Full-adder slice for the current bit. In subtract mode b is inverted
   // here; the "+1" of the two's complement comes from the carry preload.
   always_comb begin
      b_eff       = b ^ mode;
      s_bit       = a ^ b_eff ^ carry;
      c_next      = (a & b_eff) | (a & carry) | (b_eff & carry);
      accept      = (state == RUN) && in_valid;
      last_accept = accept && (bit_cnt == LAST_BIT);
   end

   // State register. Reset can hit at any time and simply abandons the
   // word in flight; no completion is reported for it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. start is only looked at in IDLE, so a start pulse
   // seen during RUN or in the DONE cycle is dropped rather than queued.
   // DONE always lasts exactly one cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_accept) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output decode from state: busy covers the whole span from the edge
   // that accepts start up to the DONE->IDLE edge.
   always_comb begin
      busy = (state != IDLE);
   end

   // Datapath registers. On start the mode is latched and the carry is
   // preloaded (1 for subtract). Each accepted bit shifts the sum into
   // sum_word from the top so that after WIDTH bits the LSB has reached
   // bit 0. On the final bit the carry into the MSB (current carry) and the
   // carry out of the MSB (c_next) give carry_out and signed overflow.
   // A stall cycle in RUN drops out_valid but leaves all state untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode      <= 1'b0;
         carry     <= 1'b0;
         bit_cnt   <= '0;
         sum_bit   <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         sum_word  <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               done      <= 1'b0;
               if (start) begin
                  mode     <= sub;
                  carry    <= sub;
                  bit_cnt  <= '0;
                  sum_word <= '0;
               end
            end
            RUN: begin
               if (in_valid) begin
                  sum_bit   <= s_bit;
                  out_valid <= 1'b1;
                  sum_word  <= {s_bit, sum_word[WIDTH-1:1]};
                  carry     <= c_next;
                  bit_cnt   <= bit_cnt + 1'b1;
                  if (last_accept) begin
                     carry_out <= c_next;
                     overflow  <= carry ^ c_next;
                     done      <= 1'b1;
                  end
               end else begin
                  out_valid <= 1'b0;
               end
            end
            DONE: begin
               out_valid <= 1'b0;
               done      <= 1'b0;
            end
            default: begin
               out_valid <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_word.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub_word
//
// Directed bench for serial_addsub_word at WIDTH=8. Inputs are driven on the
// falling edge and outputs are sampled on the falling edge, half a cycle
// away from the active rising edge. Expected values are hand computed.
// ---------------------------------------------------------------------------
module tb_serial_addsub_word;

   logic       clk;
   logic       rst;
   logic       start;
   logic       sub;
   logic       in_valid;
   logic       a;
   logic       b;
   logic       sum_bit;
   logic       out_valid;
   logic       busy;
   logic       done;
   logic [7:0] sum_word;
   logic       carry_out;
   logic       overflow;

   int checks;
   int errors;

   serial_addsub_word #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sub       (sub),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .sum_bit   (sum_bit),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done),
      .sum_word  (sum_word),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   // 10 time-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Runs one word through the DUT and returns what was observed. When
   // do_start is 0 the caller has already had start accepted and we are at
   // the falling edge just after that accept edge. Bits stall for
   // stall_len cycles once stall_at bits have been sent; at bit index
   // noise_at start is pulsed and sub inverted. Returns at the falling edge
   // where done is seen, or after a 40-cycle budget with timed_out set.
   task automatic drive_word(input bit do_start, input logic [7:0] aw,
                             input logic [7:0] bw, input logic s,
                             input int stall_at, input int stall_len,
                             input int noise_at,
                             output logic [7:0] stream, output int done_cyc,
                             output int idle_cnt, output logic done_ov,
                             output logic timed_out);
      int i;
      int st;
      int nout;
      stream    = '0;
      done_cyc  = -1;
      idle_cnt  = 0;
      done_ov   = 1'b0;
      timed_out = 1'b1;
      i         = 0;
      st        = 0;
      nout      = 0;
      if (do_start) begin
         @(negedge clk);
         start    = 1'b1;
         sub      = s;
         in_valid = 1'b0;
         @(negedge clk);
         start = 1'b0;
      end
      for (int cyc = 1; cyc <= 40; cyc++) begin
         start = 1'b0;
         sub   = s;
         if (i == noise_at) begin
            start = 1'b1;
            sub   = ~s;
         end
         if (i < 8 && i == stall_at && st < stall_len) begin
            in_valid = 1'b0;
            st++;
         end else if (i < 8) begin
            in_valid = 1'b1;
            a        = aw[i];
            b        = bw[i];
            i++;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (out_valid) begin
            if (nout < 8) stream[nout] = sum_bit;
            nout++;
         end else begin
            idle_cnt++;
         end
         if (done) begin
            done_cyc  = cyc;
            done_ov   = out_valid;
            timed_out = 1'b0;
            break;
         end
      end
      start    = 1'b0;
      sub      = 1'b0;
      in_valid = 1'b0;
   endtask

   // Power-on reset: every output must be zero while rst is low.
   task automatic test_reset();
      rst      = 1'b0;
      start    = 1'b0;
      sub      = 1'b0;
      in_valid = 1'b0;
      a        = 1'b0;
      b        = 1'b0;
      #12;
      checks++;
      if ({busy, done, out_valid, sum_bit, carry_out, overflow} !== 6'b0 ||
          sum_word !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got busy=%b done=%b ov=%b sb=%b co=%b of=%b sw=%h, expected all 0",
                  busy, done, out_valid, sum_bit, carry_out, overflow, sum_word);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_idle_busy: got %b, expected 0", busy);
      end
   endtask

   // Basic add 0x35+0x4A with serial stream, done alignment and return to idle.
   task automatic test_add();
      logic [7:0] stream;
      int         dc;
      int         ic;
      logic       dov;
      logic       to;
      drive_word(1'b1, 8'h35, 8'h4A, 1'b0, 99, 0, 99, stream, dc, ic, dov, to);
      checks++;
      if (stream !== 8'h7F) begin
         errors++;
         $display("[TB] FAIL add_stream: got %h, expected 7f", stream);
      end
      checks++;
      if (sum_word !== 8'h7F || carry_out !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL add_result: got sw=%h co=%b of=%b, expected sw=7f co=0 of=0",
                  sum_word, carry_out, overflow);
      end
      checks++;
      if (dc !== 8 || dov !== 1'b1 || to !== 1'b0) begin
         errors++;
         $display("[TB] FAIL add_done_timing: got cycle=%0d with_out_valid=%b, expected cycle=8 with_out_valid=1",
                  dc, dov);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL add_busy_in_done: got %b, expected 1", busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || sum_word !== 8'h7F) begin
         errors++;
         $display("[TB] FAIL add_after_done: got busy=%b done=%b ov=%b sw=%h, expected 0 0 0 7f",
                  busy, done, out_valid, sum_word);
      end
   endtask

   // Add boundary cases: signed overflow without carry, carry without overflow.
   task automatic test_add_boundaries();
      logic [7:0] stream;
      int         dc;
      int         ic;
      logic       dov;
      logic       to;
      drive_word(1'b1, 8'h7F, 8'h01, 1'b0, 99, 0, 99, stream, dc, ic, dov, to);
      checks++;
      if (to !== 1'b0 || sum_word !== 8'h80 || carry_out !== 1'b0 || overflow !== 1'b1) begin
         errors++;
         $display("[TB] FAIL add_7f_01: got sw=%h co=%b of=%b timeout=%b, expected sw=80 co=0 of=1",
                  sum_word, carry_out, overflow, to);
      end
      drive_word(1'b1, 8'hFF, 8'h01, 1'b0, 99, 0, 99, stream, dc, ic, dov, to);
      checks++;
      if (to !== 1'b0 || sum_word !== 8'h00 || carry_out !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL add_ff_01: got sw=%h co=%b of=%b timeout=%b, expected sw=00 co=1 of=0",
                  sum_word, carry_out, overflow, to);
      end
   endtask

   // Subtract cases: plain, borrow, and signed overflow.
   task automatic test_subtract();
      logic [7:0] stream;
      int         dc;
      int         ic;
      logic       dov;
      logic       to;
      drive_word(1'b1, 8'h10, 8'h01, 1'b1, 99, 0, 99, stream, dc, ic, dov, to);
      checks++;
      if (to !== 1'b0 || sum_word !== 8'h0F || carry_out !== 1'b1 || overflow !== 1'b0 ||
          stream !== 8'h0F) begin
         errors++;
         $display("[TB] FAIL sub_10_01: got sw=%h stream=%h co=%b of=%b, expected sw=0f stream=0f co=1 of=0",
                  sum_word, stream, carry_out, overflow);
      end
      drive_word(1'b1, 8'h00, 8'h01, 1'b1, 99, 0, 99, stream, dc, ic, dov, to);
      checks++;
      if (to !== 1'b0 || sum_word !== 8'hFF || carry_out !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sub_00_01: got sw=%h co=%b of=%b, expected sw=ff co=0 of=0",
                  sum_word, carry_out, overflow);
      end
      drive_word(1'b1, 8'h80, 8'h01, 1'b1, 99, 0, 99, stream, dc, ic, dov, to);
      checks++;
      if (to !== 1'b0 || sum_word !== 8'h7F || carry_out !== 1'b1 || overflow !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sub_80_01: got sw=%h co=%b of=%b, expected sw=7f co=1 of=1",
                  sum_word, carry_out, overflow);
      end
      @(negedge clk);
   endtask

   // Reset asserted after 4 bits of a word: outputs clear at once, then a
   // fresh subtract word runs normally.
   task automatic test_reset_mid_word();
      logic [7:0] stream;
      int         dc;
      int         ic;
      logic       dov;
      logic       to;
      logic [7:0] av;
      logic [7:0] bv;
      av = 8'h35;
      bv = 8'h4A;
      @(negedge clk);
      start = 1'b1;
      sub   = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         a        = av[i];
         b        = bv[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || sum_word !== 8'hF0) begin
         errors++;
         $display("[TB] FAIL midword_partial: got busy=%b sw=%h, expected busy=1 sw=f0", busy, sum_word);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, done, out_valid, sum_bit, carry_out, overflow} !== 6'b0 ||
          sum_word !== 8'h00) begin
         errors++;
         $display("[TB] FAIL midword_reset: got busy=%b done=%b ov=%b sb=%b co=%b of=%b sw=%h, expected all 0",
                  busy, done, out_valid, sum_bit, carry_out, overflow, sum_word);
      end
      @(negedge clk);
      rst = 1'b1;
      drive_word(1'b1, 8'h05, 8'h03, 1'b1, 99, 0, 99, stream, dc, ic, dov, to);
      checks++;
      if (to !== 1'b0 || sum_word !== 8'h02 || carry_out !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midword_fresh_sub: got sw=%h co=%b of=%b, expected sw=02 co=1 of=0",
                  sum_word, carry_out, overflow);
      end
      @(negedge clk);
   endtask

   // Three stall cycles after bit 3: same result, done 3 cycles later.
   task automatic test_stall();
      logic [7:0] stream;
      int         dc;
      int         ic;
      logic       dov;
      logic       to;
      drive_word(1'b1, 8'h35, 8'h4A, 1'b0, 4, 3, 99, stream, dc, ic, dov, to);
      checks++;
      if (stream !== 8'h7F || sum_word !== 8'h7F) begin
         errors++;
         $display("[TB] FAIL stall_result: got stream=%h sw=%h, expected 7f 7f", stream, sum_word);
      end
      checks++;
      if (dc !== 11 || ic !== 3 || dov !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_timing: got done_cycle=%0d idle_cycles=%0d, expected 11 and 3", dc, ic);
      end
      @(negedge clk);
   endtask

   // Start and sub toggled mid-word are ignored; start in the DONE cycle is
   // ignored; start in the following IDLE cycle is accepted.
   task automatic test_ignored_controls();
      logic [7:0] stream;
      int         dc;
      int         ic;
      logic       dov;
      logic       to;
      drive_word(1'b1, 8'h10, 8'h01, 1'b1, 99, 0, 2, stream, dc, ic, dov, to);
      checks++;
      if (to !== 1'b0 || dc !== 8 || sum_word !== 8'h0F || carry_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ignore_midrun: got sw=%h co=%b done_cycle=%0d, expected sw=0f co=1 done_cycle=8",
                  sum_word, carry_out, dc);
      end
      start = 1'b1;
      sub   = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || sum_word !== 8'h0F) begin
         errors++;
         $display("[TB] FAIL ignore_start_in_done: got busy=%b sw=%h, expected busy=0 sw=0f", busy, sum_word);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || sum_word !== 8'h00) begin
         errors++;
         $display("[TB] FAIL start_in_idle: got busy=%b sw=%h, expected busy=1 sw=00", busy, sum_word);
      end
      drive_word(1'b0, 8'h35, 8'h4A, 1'b0, 99, 0, 99, stream, dc, ic, dov, to);
      checks++;
      if (to !== 1'b0 || dc !== 8 || sum_word !== 8'h7F || stream !== 8'h7F) begin
         errors++;
         $display("[TB] FAIL restart_add: got sw=%h stream=%h done_cycle=%0d, expected 7f 7f 8",
                  sum_word, stream, dc);
      end
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_add_boundaries();
      test_subtract();
      test_reset_mid_word();
      test_stall();
      test_ignored_controls();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_addsub_word.md
Name: serial_addsub_word

Overview:
- Word-framed bit-serial adder/subtractor.
- Operands arrive LSB first, one bit pair per accepted cycle. The block keeps a one-bit carry state across bits and emits one sum bit per accepted bit.
- After WIDTH bits it presents the parallel result, carry-out and signed overflow.
- Sits between serial operand sources and parallel consumers in the arithmetic datapath.

Parameters:
WIDTH, 8, bits per word; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begins a new word; honoured only in IDLE
sub  input  1  mode, sampled with start: 0 = a+b, 1 = a-b
in_valid  input  1  a/b bit pair valid this cycle
a  input  1  serial operand A bit, LSB first
b  input  1  serial operand B bit, LSB first
sum_bit  output  1  registered serial result bit
out_valid  output  1  sum_bit carries a new bit this cycle
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; word complete
sum_word  output  WIDTH  parallel result, held until next start
carry_out  output  1  final carry (sub: 1 = no borrow, i.e. a >= b unsigned)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst=0, any time, async): state=IDLE; carry, bit counter, sum_bit, out_valid, done, sum_word, carry_out, overflow all 0. Reset mid-word aborts the word; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch mode<=sub; carry<=sub (subtract is a + ~b + 1); bit_cnt<=0; sum_word<=0; go to RUN. in_valid is ignored in IDLE.
- RUN, in_valid=1:
  - b_eff = b ^ mode; s = a ^ b_eff ^ carry; c_next = majority(a, b_eff, carry).
  - sum_bit<=s; out_valid<=1; sum_word shifts right with s entering bit WIDTH-1; carry<=c_next; bit_cnt++.
- RUN, in_valid=0: out_valid<=0; sum_bit, carry, bit_cnt and sum_word hold.
- Last bit (bit_cnt==WIDTH-1 and in_valid=1): carry_out<=c_next; overflow<=carry^c_next (carry into MSB XOR carry out of MSB); done<=1; go to DONE.
- DONE: lasts exactly one cycle.
  - done=1, coinciding with out_valid=1 for the MSB sum_bit.
  - sum_word, carry_out and overflow are valid from this cycle and held until the next accepted start.
  - Next edge: go to IDLE; done<=0, out_valid<=0.
- start is ignored in RUN and DONE (no restart, no error). sub is ignored except in the start cycle.
- Latency: each sum_bit appears the cycle after its a/b pair is accepted. With no stalls, done appears WIDTH cycles after the start-accept edge. Minimum start-to-start spacing is WIDTH+2 cycles.
- sum_word wraps modulo 2^WIDTH; carry_out/overflow carry the out-of-range information.
- busy=1 from the edge accepting start until the DONE->IDLE edge.

Test Plan:
- Add, WIDTH=8: start, sub=0, a=0x35, b=0x4A, 8 consecutive bits -> sum_bit stream LSB-first of 0x7F; sum_word=0x7F, carry_out=0, overflow=0; done pulse in the same cycle as the 8th out_valid.
- Add boundaries: 0x7F+0x01 -> 0x80, carry_out=0, overflow=1. 0xFF+0x01 -> 0x00, carry_out=1, overflow=0.
- Subtract: 0x10-0x01 -> 0x0F, carry_out=1, overflow=0. 0x00-0x01 -> 0xFF, carry_out=0. 0x80-0x01 -> 0x7F, overflow=1.
- Stall: add 0x35+0x4A with in_valid low for 3 cycles after bit 3 -> out_valid low for those 3 cycles, result still 0x7F, done 3 cycles later than in the no-stall case.
- Ignored controls: start pulsed and sub toggled mid-RUN -> no restart, mode unchanged, correct result. start in the DONE cycle -> ignored; start in the following IDLE cycle is accepted.
- Reset mid-word: rst=0 after 4 bits -> all outputs 0 and busy=0 immediately (async). After release, a fresh sub word 0x05-0x03 -> 0x02, carry_out=1, overflow=0.
